// File: rtl/axil_cmd_master_pkg.sv
// ============================================================================
// Module   : axil_cmd_master_pkg
// Brief    : Shared AXI4-Lite response codes and state encoding for
//            axil_cmd_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_cmd_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RSP          = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/axil_cmd_master.sv
// ============================================================================
// Module   : axil_cmd_master
// Brief    : Single-outstanding AXI4-Lite master driven by a valid/ready
//            command stream; completions return on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_cmd_master
    import axil_cmd_master_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 16,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,

    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,

    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_t                  state, state_nxt;
    logic                    cmd_ready_nxt;
    logic                    awvalid_nxt, wvalid_nxt, bready_nxt;
    logic                    arvalid_nxt, rready_nxt;
    logic                    rsp_valid_nxt, rsp_write_nxt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
    logic [1:0]              rsp_resp_nxt;
    logic                    aw_done, aw_done_nxt;
    logic                    w_done, w_done_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_nxt;

    // One address register serves both AW and AR; only one is ever valid.
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_awprot = PROT;
    assign m_axil_arprot = PROT;

    always_comb begin
        state_nxt     = state;
        cmd_ready_nxt = cmd_ready;
        awvalid_nxt   = m_axil_awvalid;
        wvalid_nxt    = m_axil_wvalid;
        bready_nxt    = m_axil_bready;
        arvalid_nxt   = m_axil_arvalid;
        rready_nxt    = m_axil_rready;
        rsp_valid_nxt = rsp_valid;
        rsp_write_nxt = rsp_write;
        rsp_rdata_nxt = rsp_rdata;
        rsp_resp_nxt  = rsp_resp;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        wstrb_nxt     = wstrb_q;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_nxt = 1'b0;
                    addr_nxt      = cmd_addr;
                    wdata_nxt     = cmd_wdata;
                    wstrb_nxt     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                        state_nxt   = ST_WR_ADDR_DATA;
                    end else begin
                        arvalid_nxt = 1'b1;
                        state_nxt   = ST_RD_ADDR;
                    end
                end
            end

            // AW and W complete independently; move on once both are done.
            ST_WR_ADDR_DATA: begin
                if (m_axil_awvalid && m_axil_awready) begin
                    awvalid_nxt = 1'b0;
                    aw_done_nxt = 1'b1;
                end
                if (m_axil_wvalid && m_axil_wready) begin
                    wvalid_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end
                if ((aw_done || (m_axil_awvalid && m_axil_awready)) &&
                    (w_done  || (m_axil_wvalid  && m_axil_wready))) begin
                    bready_nxt = 1'b1;
                    state_nxt  = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (m_axil_bvalid && m_axil_bready) begin
                    bready_nxt    = 1'b0;
                    rsp_write_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_resp_nxt  = m_axil_bresp;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = ST_RSP;
                end
            end

            ST_RD_ADDR: begin
                if (m_axil_arvalid && m_axil_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (m_axil_rvalid && m_axil_rready) begin
                    rready_nxt    = 1'b0;
                    rsp_write_nxt = 1'b0;
                    rsp_rdata_nxt = m_axil_rdata;
                    rsp_resp_nxt  = m_axil_rresp;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end

            default: begin
                state_nxt     = ST_IDLE;
                cmd_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b1;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= RESP_OKAY;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
        end else begin
            state          <= state_nxt;
            cmd_ready      <= cmd_ready_nxt;
            m_axil_awvalid <= awvalid_nxt;
            m_axil_wvalid  <= wvalid_nxt;
            m_axil_bready  <= bready_nxt;
            m_axil_arvalid <= arvalid_nxt;
            m_axil_rready  <= rready_nxt;
            rsp_valid      <= rsp_valid_nxt;
            rsp_write      <= rsp_write_nxt;
            rsp_rdata      <= rsp_rdata_nxt;
            rsp_resp       <= rsp_resp_nxt;
            aw_done        <= aw_done_nxt;
            w_done         <= w_done_nxt;
            addr_q         <= addr_nxt;
            wdata_q        <= wdata_nxt;
            wstrb_q        <= wstrb_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
// ============================================================================
// Module   : tb_axil_cmd_master
// Brief    : Randomized self-checking bench for axil_cmd_master with an
//            AXI4-Lite RAM slave model and a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_cmd_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic          arready = 1'b0, rvalid = 1'b0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [DW-1:0] rdata = '0;

    axil_cmd_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave behaviour knobs, set by the stimulus process only.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  err_resp = 2'b00;
    logic [31:0] err_data = '0;

    // Slave model state and observations, written by the slave process only.
    logic [31:0] slv_mem [16];
    bit          aw_got, w_got, ar_got, b_started;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_total = 0, w_total = 0, b_total = 0, ar_total = 0, r_total = 0;
    int          stab_err = 0;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [DW-1:0] last_wdata;
    logic [SW-1:0] last_wstrb;
    logic          awv_p, awr_p, wv_p, wr_p, bv_p, br_p, arv_p, arr_p, rv_p, rr_p;
    logic [AW-1:0] awaddr_p, araddr_p;
    logic [DW-1:0] wdata_p;
    logic [SW-1:0] wstrb_p;

    // RAM slave: acts on falling edges; a handshake happened at the rising
    // edge in between iff valid and ready were both high at the last fall.
    initial begin
        for (int i = 0; i < 16; i++) slv_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_started = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                {awv_p, awr_p, wv_p, wr_p, bv_p, br_p, arv_p, arr_p, rv_p, rr_p} = '0;
                continue;
            end
            if (awv_p && !awr_p && (!awvalid || awaddr !== awaddr_p)) stab_err++;
            if (wv_p && !wr_p && (!wvalid || wdata !== wdata_p || wstrb !== wstrb_p)) stab_err++;
            if (arv_p && !arr_p && (!arvalid || araddr !== araddr_p)) stab_err++;
            if ((aw_got && awvalid) || (w_got && wvalid) || (ar_got && arvalid)) stab_err++;

            if (awv_p && awr_p) begin aw_got = 1; aw_total++; last_awaddr = awaddr_p; awready = 0; end
            if (wv_p && wr_p) begin
                w_got = 1; w_total++; last_wdata = wdata_p; last_wstrb = wstrb_p; wready = 0;
            end
            if (arv_p && arr_p) begin ar_got = 1; ar_total++; last_araddr = araddr_p; arready = 0; r_cnt = 0; end
            if (bv_p && br_p) begin
                bvalid = 0; b_total++; aw_got = 0; w_got = 0; b_started = 0; aw_cnt = 0; w_cnt = 0;
            end
            if (rv_p && rr_p) begin rvalid = 0; r_total++; ar_got = 0; ar_cnt = 0; end

            if (awvalid && !aw_got && !awready) begin
                if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
            end
            if (wvalid && !w_got && !wready) begin
                if (w_cnt >= w_delay) wready = 1; else w_cnt++;
            end
            if (arvalid && !ar_got && !arready) begin
                if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
            end
            if (aw_got && w_got && !b_started) begin
                b_started = 1; b_cnt = 0;
                if (err_resp == 2'b00)
                    for (int b = 0; b < SW; b++)
                        if (last_wstrb[b]) slv_mem[last_awaddr[5:2]][8*b +: 8] = last_wdata[8*b +: 8];
            end
            if (b_started && !bvalid) begin
                if (b_cnt >= b_delay) begin bvalid = 1; bresp = err_resp; end else b_cnt++;
            end
            if (ar_got && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid = 1; rresp = err_resp;
                    rdata  = (err_resp != 2'b00) ? err_data : slv_mem[last_araddr[5:2]];
                end else r_cnt++;
            end

            awv_p = awvalid; awr_p = awready; awaddr_p = awaddr;
            wv_p = wvalid; wr_p = wready; wdata_p = wdata; wstrb_p = wstrb;
            bv_p = bvalid; br_p = bready; arv_p = arvalid; arr_p = arready; araddr_p = araddr;
            rv_p = rvalid; rr_p = rready;
        end
    end

    // Reference model: what a word-addressed memory should hold.
    logic [31:0] ref_mem [16];

    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input int bp, input bit chk_lat,
                           output logic [DW-1:0] got);
        int t, lat;
        int aw0, w0, b0, ar0, r0, s0;
        logic [DW-1:0] exp_rdata, held;
        aw0 = aw_total; w0 = w_total; b0 = b_total; ar0 = ar_total; r0 = r_total; s0 = stab_err;
        got = '0;
        if (wr) begin
            exp_rdata = '0;
            if (err_resp == 2'b00)
                for (int b = 0; b < SW; b++)
                    if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
        end else begin
            exp_rdata = (err_resp != 2'b00) ? err_data : ref_mem[addr[5:2]];
        end

        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        t = 0;
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        check_eq("cmd_accept", cmd_ready, 1);
        if (!cmd_ready) begin cmd_valid = 0; return; end
        @(negedge clk);
        cmd_valid = 0;
        check_eq("cmd_ready_drop", cmd_ready, 0);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        check_eq("rsp_arrive", rsp_valid, 1);
        if (!rsp_valid) return;
        if (chk_lat) check_eq("latency", lat, 3);
        check_eq("rsp_write", rsp_write, wr);
        check_eq("rsp_resp", rsp_resp, err_resp);
        check_eq("rsp_rdata", rsp_rdata, exp_rdata);
        got  = rsp_rdata;
        held = rsp_rdata;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", rsp_valid, 1);
            check_eq("bp_rsp_rdata", rsp_rdata, held);
            check_eq("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check_eq("rsp_valid_clr", rsp_valid, 0);
        check_eq("cmd_ready_back", cmd_ready, 1);
        if (wr) begin
            check_eq("aw_beats", aw_total - aw0, 1);
            check_eq("w_beats", w_total - w0, 1);
            check_eq("b_beats", b_total - b0, 1);
            check_eq("awaddr", last_awaddr, addr);
            check_eq("wdata", last_wdata, data);
            check_eq("wstrb", last_wstrb, strb);
        end else begin
            check_eq("ar_beats", ar_total - ar0, 1);
            check_eq("r_beats", r_total - r0, 1);
            check_eq("araddr", last_araddr, addr);
        end
        check_eq("axi_stability", stab_err - s0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] got;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_rsp_resp", rsp_resp, 0);
        check_eq("rst_addr", awaddr, 0);
        check_eq("prot", {awprot, arprot}, 0);
        rst = 1;

        run_cmd(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 1, got);
        run_cmd(0, 16'h0010, 32'h0, 4'h0, 0, 1, got);
        check_eq("readback", got, 32'hDEADBEEF);

        run_cmd(1, 16'h0020, 32'h11223344, 4'hF, 0, 0, got);
        run_cmd(1, 16'h0020, 32'hAABBCCDD, 4'b0101, 0, 0, got);
        run_cmd(0, 16'h0020, 32'h0, 4'h0, 0, 0, got);
        check_eq("partial_strobe", got, 32'h11BB33DD);

        aw_delay = 5;
        run_cmd(1, 16'h0030, 32'hCAFEF00D, 4'hF, 0, 0, got);
        aw_delay = 0;

        run_cmd(0, 16'h0010, 32'h0, 4'h0, 10, 0, got);
        check_eq("bp_readback", got, 32'hDEADBEEF);

        err_resp = 2'b10; err_data = 32'hBAD0BAD0;
        run_cmd(0, 16'h0020, 32'h0, 4'h0, 0, 0, got);
        check_eq("err_rdata", got, 32'hBAD0BAD0);
        err_resp = 2'b00;

        // Abandon a read with AR still pending.
        ar_delay = 1000;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0010;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check_eq("arvalid_before_rst", arvalid, 1);
        rst = 0;
        #1;
        check_eq("arvalid_async_clr", arvalid, 0);
        check_eq("cmd_ready_in_rst", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1; ar_delay = 0;
        @(negedge clk);
        check_eq("cmd_ready_after_rst", cmd_ready, 1);
        run_cmd(1, 16'h0004, 32'h5A5A1234, 4'hF, 0, 1, got);
        run_cmd(0, 16'h0004, 32'h0, 4'h0, 0, 0, got);
        check_eq("post_rst_readback", got, 32'h5A5A1234);

        for (int n = 0; n < 40; n++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            err_resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            err_data = $urandom;
            run_cmd(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15) << 2), $urandom,
                    4'($urandom), $urandom_range(0, 3), 0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
